// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the streaming UART transmitter.
// Revision 1.0
`default_nettype none

package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'b00,
      PAR_ODD  = 2'b01,
      PAR_EVEN = 2'b10
   } parity_t;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   localparam int MIN_DIV = 2;

   // Encoding 11 is reserved and behaves as no parity.
   function automatic parity_t decode_parity(input logic [1:0] cfg);
      case (cfg)
         2'b01:   return PAR_ODD;
         2'b10:   return PAR_EVEN;
         default: return PAR_NONE;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered level and full flag.
// Revision 1.0
`default_nettype none

module sync_fifo #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          push,
   input  logic                          pop,
   input  logic [DATA_W-1:0]             din,
   output logic [DATA_W-1:0]             dout,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          full,
   output logic                          empty
);

   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int LEVEL_W = PTR_W + 1;

   logic [DATA_W-1:0]  mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [LEVEL_W-1:0] level_q;
   logic [LEVEL_W-1:0] level_n;
   logic               full_q;
   logic               do_push;
   logic               do_pop;

   assign do_push = push && !full_q;
   assign do_pop  = pop && (level_q != '0);

   always_comb begin
      level_n = level_q;
      case ({do_push, do_pop})
         2'b10:   level_n = level_q + 1'b1;
         2'b01:   level_n = level_q - 1'b1;
         default: level_n = level_q;
      endcase
   end

   // Full is kept as a register so the upstream ready has no combinational input path.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
         full_q  <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         level_q <= level_n;
         full_q  <= (level_n == LEVEL_W'(FIFO_DEPTH));
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   assign dout  = mem[rd_ptr];
   assign level = level_q;
   assign full  = full_q;
   assign empty = (level_q == '0);

endmodule

`default_nettype wire

// File: rtl/uart_tx_stream.sv
// uart_tx_stream: streaming UART transmitter with input FIFO, runtime baud/parity/stop config.
// Revision 1.0
`default_nettype none

module uart_tx_stream
   import uart_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int DIV_W      = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [DIV_W-1:0]            cfg_div,
   input  logic [1:0]                  cfg_parity,
   input  logic                        cfg_stop2,
   input  logic                        s_valid,
   output logic                        s_ready,
   input  logic [DATA_W-1:0]           s_data,
   output logic                        data_tx,
   output logic                        active_flag,
   output logic                        done_flag,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

   localparam int IDX_W = $clog2(DATA_W);

   state_t             state, state_n;
   logic [DIV_W-1:0]   cnt, cnt_n;
   logic [DIV_W-1:0]   div_q, div_n;
   logic [IDX_W-1:0]   bit_idx, bit_idx_n;
   logic [DATA_W-1:0]  shift, shift_n;
   logic               par_en, par_en_n;
   logic               par_bit, par_bit_n;
   logic               stop2_q, stop2_n;
   logic               stop_idx, stop_idx_n;
   logic               tx, tx_n;

   logic [DATA_W-1:0]  fifo_dout;
   logic               fifo_full;
   logic               fifo_empty;
   logic               push;
   logic               pop;
   logic               bit_end;
   logic               frame_end;
   parity_t            cfg_par;
   logic [DIV_W-1:0]   cfg_div_eff;

   sync_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (s_data),
      .dout  (fifo_dout),
      .level (fifo_level),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign s_ready     = !fifo_full;
   assign push        = s_valid && s_ready;
   assign cfg_par     = decode_parity(cfg_parity);
   assign cfg_div_eff = (cfg_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : cfg_div;

   assign bit_end     = (cnt == div_q - 1'b1);
   assign frame_end   = (state == ST_STOP) && bit_end && (stop_idx == stop2_q);
   assign pop         = !fifo_empty && ((state == ST_IDLE) || frame_end);

   assign data_tx     = tx;
   assign active_flag = (state != ST_IDLE);
   assign done_flag   = frame_end;

   always_comb begin
      state_n    = state;
      cnt_n      = bit_end ? '0 : cnt + 1'b1;
      div_n      = div_q;
      bit_idx_n  = bit_idx;
      shift_n    = shift;
      par_en_n   = par_en;
      par_bit_n  = par_bit;
      stop2_n    = stop2_q;
      stop_idx_n = stop_idx;
      tx_n       = tx;

      case (state)
         ST_IDLE: begin
            cnt_n = '0;
            tx_n  = 1'b1;
         end
         ST_START: begin
            if (bit_end) begin
               state_n   = ST_DATA;
               bit_idx_n = '0;
               tx_n      = shift[0];
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               if (bit_idx == IDX_W'(DATA_W - 1)) begin
                  if (par_en) begin
                     state_n = ST_PARITY;
                     tx_n    = par_bit;
                  end else begin
                     state_n    = ST_STOP;
                     stop_idx_n = 1'b0;
                     tx_n       = 1'b1;
                  end
               end else begin
                  bit_idx_n = bit_idx + 1'b1;
                  shift_n   = shift >> 1;
                  tx_n      = shift[1];
               end
            end
         end
         ST_PARITY: begin
            if (bit_end) begin
               state_n    = ST_STOP;
               stop_idx_n = 1'b0;
               tx_n       = 1'b1;
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               if (stop_idx == stop2_q) begin
                  state_n = ST_IDLE;
                  tx_n    = 1'b1;
               end else begin
                  stop_idx_n = 1'b1;
               end
            end
         end
         default: begin
            state_n = ST_IDLE;
            tx_n    = 1'b1;
         end
      endcase

      // A pop overrides the above: configuration is captured with the word.
      if (pop) begin
         state_n   = ST_START;
         cnt_n     = '0;
         tx_n      = 1'b0;
         shift_n   = fifo_dout;
         div_n     = cfg_div_eff;
         par_en_n  = (cfg_par != PAR_NONE);
         par_bit_n = (cfg_par == PAR_EVEN) ? ^fifo_dout : ~^fifo_dout;
         stop2_n   = cfg_stop2;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         div_q    <= DIV_W'(MIN_DIV);
         bit_idx  <= '0;
         shift    <= '0;
         par_en   <= 1'b0;
         par_bit  <= 1'b0;
         stop2_q  <= 1'b0;
         stop_idx <= 1'b0;
         tx       <= 1'b1;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         div_q    <= div_n;
         bit_idx  <= bit_idx_n;
         shift    <= shift_n;
         par_en   <= par_en_n;
         par_bit  <= par_bit_n;
         stop2_q  <= stop2_n;
         stop_idx <= stop_idx_n;
         tx       <= tx_n;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_stream.sv
// tb_uart_tx_stream: randomized self-checking bench against a per-bit frame model.
// Revision 1.0
`default_nettype none

module tb_uart_tx_stream;

   localparam int DATA_W = 8;
   localparam int DIV_W  = 16;
   localparam int DEPTH  = 4;

   logic              clock = 1'b0;
   logic              reset;
   logic [DIV_W-1:0]  cfg_div;
   logic [1:0]        cfg_parity;
   logic              cfg_stop2;
   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_data;
   logic              data_tx;
   logic              active_flag;
   logic              done_flag;
   logic [2:0]        fifo_level;

   int checks   = 0;
   int failures = 0;

   bit   exp_tx[$];
   bit   exp_done[$];
   logic obs_tx[$];
   logic obs_done[$];
   logic obs_act[$];
   logic obs_rdy[$];
   logic [2:0] obs_lvl[$];

   uart_tx_stream #(
      .DATA_W     (DATA_W),
      .DIV_W      (DIV_W),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .cfg_div     (cfg_div),
      .cfg_parity  (cfg_parity),
      .cfg_stop2   (cfg_stop2),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .data_tx     (data_tx),
      .active_flag (active_flag),
      .done_flag   (done_flag),
      .fifo_level  (fifo_level)
   );

   always #5 clock = ~clock;

   initial begin
      #600000;
      $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Reference frame: start, LSB-first data, optional parity, stop(s); each bit held max(div,2) clocks.
   task automatic add_frame(input logic [7:0] d, input int div, input logic [1:0] par, input bit stop2);
      int de;
      bit bits[$];
      de = (div < 2) ? 2 : div;
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(d[i]);
      if (par == 2'b01) bits.push_back(~^d);
      else if (par == 2'b10) bits.push_back(^d);
      bits.push_back(1'b1);
      if (stop2) bits.push_back(1'b1);
      foreach (bits[b]) begin
         for (int k = 0; k < de; k++) begin
            exp_tx.push_back(bits[b]);
            exp_done.push_back(1'b0);
         end
      end
      exp_done[exp_done.size()-1] = 1'b1;
   endtask

   task automatic capture(input int n, input int chg_at, input logic [DIV_W-1:0] chg_val);
      obs_tx.delete(); obs_done.delete(); obs_act.delete(); obs_rdy.delete(); obs_lvl.delete();
      for (int i = 0; i < n; i++) begin
         if (i == chg_at) cfg_div = chg_val;
         obs_tx.push_back(data_tx);
         obs_done.push_back(done_flag);
         obs_act.push_back(active_flag);
         obs_rdy.push_back(s_ready);
         obs_lvl.push_back(fifo_level);
         tick();
      end
   endtask

   // Leaves the bench two cycles after acceptance, i.e. at the expected start bit.
   task automatic push_word(input logic [7:0] d);
      s_valid = 1'b1;
      s_data  = d;
      tick();
      s_valid = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1; s_valid = 1'b0; s_data = '0;
      cfg_div = 16'd4; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      checks++; if (data_tx !== 1'b1)     begin failures++; $display("FAIL reset data_tx got=%b exp=1", data_tx); end
      checks++; if (active_flag !== 1'b0) begin failures++; $display("FAIL reset active got=%b exp=0", active_flag); end
      checks++; if (done_flag !== 1'b0)   begin failures++; $display("FAIL reset done got=%b exp=0", done_flag); end
      checks++; if (s_ready !== 1'b1)     begin failures++; $display("FAIL reset s_ready got=%b exp=1", s_ready); end
      checks++; if (fifo_level !== 3'd0)  begin failures++; $display("FAIL reset level got=%0d exp=0", fifo_level); end
   endtask

   task automatic test_single_even();
      cfg_div = 16'd4; cfg_parity = 2'b10; cfg_stop2 = 1'b0;
      exp_tx.delete(); exp_done.delete();
      add_frame(8'hA5, 4, 2'b10, 1'b0);
      push_word(8'hA5);
      capture(exp_tx.size() + 1, -1, '0);
      checks++; if (exp_tx.size() !== 44) begin failures++; $display("FAIL even_len got=%0d exp=44", exp_tx.size()); end
      for (int i = 0; i < exp_tx.size(); i++) begin
         checks++;
         if (obs_tx[i] !== exp_tx[i] || obs_done[i] !== exp_done[i] || obs_act[i] !== 1'b1) begin
            failures++;
            $display("FAIL even_frame cyc=%0d tx=%b exp=%b done=%b exp=%b act=%b exp=1",
                     i, obs_tx[i], exp_tx[i], obs_done[i], exp_done[i], obs_act[i]);
         end
      end
      checks++; if (obs_act[44] !== 1'b0) begin failures++; $display("FAIL even_active_fall got=%b exp=0", obs_act[44]); end
   endtask

   task automatic test_odd_stop2();
      cfg_div = 16'd2; cfg_parity = 2'b01; cfg_stop2 = 1'b1;
      exp_tx.delete(); exp_done.delete();
      add_frame(8'h01, 2, 2'b01, 1'b1);
      push_word(8'h01);
      capture(exp_tx.size() + 1, -1, '0);
      checks++; if (obs_tx[18] !== 1'b0) begin failures++; $display("FAIL odd_parity_bit got=%b exp=0", obs_tx[18]); end
      for (int i = 0; i < exp_tx.size(); i++) begin
         checks++;
         if (obs_tx[i] !== exp_tx[i] || obs_done[i] !== exp_done[i] || obs_act[i] !== 1'b1) begin
            failures++;
            $display("FAIL odd_frame cyc=%0d tx=%b exp=%b done=%b exp=%b act=%b exp=1",
                     i, obs_tx[i], exp_tx[i], obs_done[i], exp_done[i], obs_act[i]);
         end
      end
      checks++; if (obs_act[24] !== 1'b0) begin failures++; $display("FAIL odd_active_fall got=%b exp=0", obs_act[24]); end
   endtask

   // First iteration uses cfg_div=0, which must behave as 2.
   task automatic test_random_frames();
      for (int r = 0; r < 6; r++) begin
         int          div;
         logic [1:0]  par;
         bit          st2;
         logic [7:0]  d;
         div = (r == 0) ? 0 : int'($urandom_range(1, 6));
         par = 2'($urandom_range(0, 3));
         st2 = 1'($urandom_range(0, 1));
         d   = 8'($urandom_range(0, 255));
         cfg_div = DIV_W'(div); cfg_parity = par; cfg_stop2 = st2;
         exp_tx.delete(); exp_done.delete();
         add_frame(d, div, par, st2);
         push_word(d);
         capture(exp_tx.size() + 1, -1, '0);
         for (int i = 0; i < exp_tx.size(); i++) begin
            checks++;
            if (obs_tx[i] !== exp_tx[i] || obs_done[i] !== exp_done[i] || obs_act[i] !== 1'b1) begin
               failures++;
               $display("FAIL rand_frame r=%0d div=%0d par=%0d cyc=%0d tx=%b exp=%b done=%b exp=%b act=%b",
                        r, div, par, i, obs_tx[i], exp_tx[i], obs_done[i], exp_done[i], obs_act[i]);
            end
         end
         checks++;
         if (obs_act[exp_tx.size()] !== 1'b0 || obs_tx[exp_tx.size()] !== 1'b1) begin
            failures++;
            $display("FAIL rand_idle r=%0d act=%b exp=0 tx=%b exp=1", r, obs_act[exp_tx.size()], obs_tx[exp_tx.size()]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] w[6];
      int         div, idx, ready_bad, pulses;
      logic [1:0] par;
      bit         st2, saw_full, over;
      div = int'($urandom_range(2, 4));
      par = 2'($urandom_range(0, 3));
      st2 = 1'($urandom_range(0, 1));
      cfg_div = DIV_W'(div); cfg_parity = par; cfg_stop2 = st2;
      exp_tx.delete(); exp_done.delete();
      for (int i = 0; i < 6; i++) begin
         w[i] = 8'($urandom_range(0, 255));
         add_frame(w[i], div, par, st2);
      end
      idx = 0;
      s_valid = 1'b1;
      s_data  = w[0];
      fork
         begin
            for (int c = 0; c < 2000 && idx < 6; c++) begin
               logic rdy;
               rdy = s_ready;
               tick();
               if (rdy) idx++;
               if (idx < 6) s_data = w[idx];
               else s_valid = 1'b0;
            end
            s_valid = 1'b0;
         end
         begin
            tick();
            tick();
            capture(exp_tx.size() + 1, -1, '0);
         end
      join
      checks++; if (idx !== 6) begin failures++; $display("FAIL b2b_accepted got=%0d exp=6", idx); end
      pulses = 0;
      for (int i = 0; i < exp_tx.size(); i++) begin
         if (obs_done[i] === 1'b1) pulses++;
         checks++;
         if (obs_tx[i] !== exp_tx[i] || obs_done[i] !== exp_done[i] || obs_act[i] !== 1'b1) begin
            failures++;
            $display("FAIL b2b_stream cyc=%0d tx=%b exp=%b done=%b exp=%b act=%b exp=1",
                     i, obs_tx[i], exp_tx[i], obs_done[i], exp_done[i], obs_act[i]);
         end
      end
      checks++; if (pulses !== 6) begin failures++; $display("FAIL b2b_done_pulses got=%0d exp=6", pulses); end
      ready_bad = 0; saw_full = 1'b0; over = 1'b0;
      foreach (obs_lvl[i]) begin
         if (obs_lvl[i] == 3'd4) saw_full = 1'b1;
         if (obs_lvl[i] > 3'd4)  over = 1'b1;
         if (obs_rdy[i] !== (obs_lvl[i] != 3'd4)) ready_bad++;
      end
      checks++; if (!saw_full) begin failures++; $display("FAIL b2b_full_reached got=0 exp=1"); end
      checks++; if (over)      begin failures++; $display("FAIL b2b_level_overflow got=1 exp=0"); end
      checks++; if (ready_bad != 0) begin failures++; $display("FAIL b2b_ready_vs_full bad_cycles=%0d exp=0", ready_bad); end
      checks++;
      if (obs_act[exp_tx.size()] !== 1'b0 || obs_lvl[exp_tx.size()] !== 3'd0) begin
         failures++;
         $display("FAIL b2b_end act=%b exp=0 level=%0d exp=0", obs_act[exp_tx.size()], obs_lvl[exp_tx.size()]);
      end
   endtask

   task automatic test_cfg_change();
      logic [7:0] a, b;
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      cfg_div = 16'd4; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
      exp_tx.delete(); exp_done.delete();
      add_frame(a, 4, 2'b00, 1'b0);
      add_frame(b, 8, 2'b00, 1'b0);
      s_valid = 1'b1; s_data = a;
      tick();
      s_data = b;
      tick();
      s_valid = 1'b0;
      capture(exp_tx.size() + 1, 12, 16'd8);
      for (int i = 0; i < exp_tx.size(); i++) begin
         checks++;
         if (obs_tx[i] !== exp_tx[i] || obs_done[i] !== exp_done[i] || obs_act[i] !== 1'b1) begin
            failures++;
            $display("FAIL cfg_change cyc=%0d tx=%b exp=%b done=%b exp=%b act=%b exp=1",
                     i, obs_tx[i], exp_tx[i], obs_done[i], exp_done[i], obs_act[i]);
         end
      end
      checks++; if (obs_act[exp_tx.size()] !== 1'b0) begin failures++; $display("FAIL cfg_change_end act=%b exp=0", obs_act[exp_tx.size()]); end
   endtask

   task automatic test_reset_mid();
      int bad;
      cfg_div = 16'd4; cfg_parity = 2'b10; cfg_stop2 = 1'b0;
      s_valid = 1'b1; s_data = 8'h3C;
      tick();
      s_data = 8'h5A;
      tick();
      s_data = 8'hC3;
      tick();
      s_valid = 1'b0;
      repeat (16) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (data_tx !== 1'b1)     begin failures++; $display("FAIL rst_mid data_tx got=%b exp=1", data_tx); end
      checks++; if (fifo_level !== 3'd0)  begin failures++; $display("FAIL rst_mid level got=%0d exp=0", fifo_level); end
      checks++; if (active_flag !== 1'b0) begin failures++; $display("FAIL rst_mid active got=%b exp=0", active_flag); end
      capture(80, -1, '0);
      bad = 0;
      foreach (obs_tx[i]) begin
         if (obs_tx[i] !== 1'b1 || obs_act[i] !== 1'b0 || obs_done[i] !== 1'b0 || obs_lvl[i] !== 3'd0) bad++;
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL rst_mid_quiet bad_cycles=%0d exp=0", bad); end
   endtask

   initial begin
      test_reset();
      test_single_even();
      test_odd_stop2();
      test_random_frames();
      test_back_to_back();
      test_cfg_change();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/uart_tx_stream.md
Name: uart_tx_stream

Overview:
Parametrised next-generation UART transmitter that merges baud generation, parity and shifting into one streaming block.
- Adds a runtime baud divisor, runtime parity/stop-bit configuration and a valid/ready input FIFO.
- Back-to-back frames are sent with no idle gap.
- Sits between a byte-producing host (CPU bus bridge or DMA) and the serial pin.

Parameters:
DATA_W, 8, data bits per frame (legal 5..9).
DIV_W, 16, width of the baud divisor input.
FIFO_DEPTH, 4, input FIFO entries (power of 2, >=2).

Ports:
clock  input  1  system clock.
reset  input  1  synchronous, active-high reset.
cfg_div  input  DIV_W  clocks per serial bit; values 0 and 1 are treated as 2.
cfg_parity  input  2  00 none, 01 odd, 10 even, 11 none.
cfg_stop2  input  1  0 = one stop bit, 1 = two stop bits.
s_valid  input  1  host has a word on s_data.
s_ready  output  1  FIFO can accept a word.
s_data  input  DATA_W  word to transmit.
data_tx  output  1  serial line, idle high.
active_flag  output  1  high from first start-bit clock through last stop-bit clock.
done_flag  output  1  single-cycle pulse on the final clock of each frame's last stop bit.
fifo_level  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Clock and reset: one clock, `clock`. Reset is synchronous and active-high, port `reset`.
- Reset values: data_tx=1, active_flag=0, done_flag=0, s_ready=1, fifo_level=0, FSM=IDLE.
  - Reset mid-frame aborts the frame and empties the FIFO.
  - data_tx is high on the cycle after reset is sampled.
- Push: a word is pushed when s_valid && s_ready.
  - s_ready = !full. It is registered from the level, with no combinational path from s_valid.
- Pop: occurs in IDLE when the FIFO is non-empty, or on the last clock of the last stop bit when the FIFO is non-empty.
- Simultaneous push and pop keep the level unchanged.
- Push into an empty FIFO is visible to pop the next cycle, not the same cycle.
- Latency: word accepted in cycle N with the block idle and the FIFO empty:
  - pop in N+1;
  - data_tx falls (start bit) in N+2.
- Config latch: cfg_div, cfg_parity and cfg_stop2 are latched at pop. Changes mid-frame do not affect the current frame.
- Bit timing: every bit lasts exactly div_eff clocks, where div_eff = max(cfg_div, 2).
  - A bit counter counts 0..div_eff-1 and is restarted at each bit boundary.
- FSM states and transitions:
  - IDLE → START on pop.
  - START → DATA.
  - DATA sends DATA_W bits, LSB first, then goes to PARITY if parity is enabled, else STOP.
  - PARITY → STOP.
  - STOP lasts 1 or 2 bit periods.
  - On the last stop clock: go to START (pop) if the FIFO is non-empty, else IDLE. There are no idle gaps between queued frames.
- Parity is computed over the DATA_W data bits:
  - even: parity bit = XOR of the data bits;
  - odd: parity bit = inverted XOR.
- Output levels: data_tx is driven from a register (glitch-free). Values per state: start=0, stop=1, IDLE=1.
- active_flag:
  - rises with the start bit;
  - stays high across back-to-back frames;
  - falls the cycle after the last stop bit when the FIFO is empty.
- done_flag pulses once per frame, coincident with the final stop-bit clock.
- Overflow: a push attempt while full is ignored (s_ready=0). There is no loss or corruption of queued words.

Decomposition:
- Package uart_pkg:
  - parity enum: PAR_NONE, PAR_ODD, PAR_EVEN;
  - FSM state enum: ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP;
  - localparam MIN_DIV = 2.
- Sub-module sync_fifo (DATA_W, FIFO_DEPTH) provides the storage, with push/pop/level/full/empty.
- FSM, baud counter and shifter stay in uart_tx_stream.

Test Plan:
- Single frame, even parity (DATA_W=8, cfg_div=4, parity 10, stop2=0, push 0xA5 at cycle N):
  - data_tx from N+2: 0, 1,0,1,0,0,1,0,1, parity 0, stop 1;
  - each level held 4 clocks, 44 clocks total;
  - done_flag high only at N+45; active_flag low at N+46.
- Odd parity, 2 stop bits (cfg_div=2, 0x01, parity 01, stop2=1):
  - parity bit = 0;
  - stop high for 4 clocks;
  - frame 24 clocks.
- FIFO backpressure: hold s_valid with 6 words while the first frame is in progress.
  - s_ready drops when fifo_level=4.
  - All 6 words appear on data_tx in order.
  - There are no gaps: each next start bit follows the last stop clock immediately.
  - Six done_flag pulses.
- Mid-frame config change: switch cfg_div 4→8 during data bits.
  - The current frame keeps 4-clock bits.
  - The next frame uses 8-clock bits.
- Reset mid-frame (reset during data bit 3 with 2 queued words):
  - data_tx=1, fifo_level=0, active_flag=0 the next cycle;
  - no further transmission.
- cfg_div=0: every bit period is 2 clocks, and the frame completes normally.
